// File: rtl/page_subdivide_pkg.sv
// Shared constants and packet-field helpers for the page subdivide router.
package page_subdivide_pkg;

  localparam int DEF_PKT_W = 49;
  localparam int MAX_PKT_W = 256;

  function automatic int unsigned valid_idx(input int unsigned pkt_w);
    return pkt_w - 1;
  endfunction

  // Packet is zero-extended to MAX_PKT_W by the caller so one helper serves any width.
  function automatic logic [31:0] sel_field(input logic [MAX_PKT_W-1:0] pkt,
                                            input int unsigned lsb,
                                            input int unsigned w);
    logic [31:0] s;
    s = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < w) s[b] = pkt[lsb + b];
    end
    return s;
  endfunction

endpackage

// File: rtl/leaf_sync_fifo.sv
// Synchronous FIFO with a combinational head and full/empty flags.
module leaf_sync_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/page_subdivide_router.sv
// Routes BFT packets to NUM_CHILD child pages by select field and round-robin merges the replies.
module page_subdivide_router
  import page_subdivide_pkg::*;
#(
  parameter int NUM_CHILD  = 4,
  parameter int PKT_W      = DEF_PKT_W,
  parameter int SEL_LSB    = 43,
  parameter int SEL_W      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [PKT_W-1:0]           din_leaf_bft2interface,
  output logic [PKT_W-1:0]           dout_leaf_interface2bft,
  input  logic                       resend_in,
  output logic                       resend_out,
  input  logic                       ap_start,
  output logic [NUM_CHILD*PKT_W-1:0] child_din,
  input  logic [NUM_CHILD-1:0]       child_ready,
  input  logic [NUM_CHILD*PKT_W-1:0] child_dout,
  output logic [NUM_CHILD-1:0]       child_resend,
  output logic [NUM_CHILD-1:0]       child_ap_start,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int VB = int'(valid_idx(PKT_W));
  localparam int PW = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

  logic [PKT_W-1:0] din_q;
  logic             resend_q, ap_q;
  logic [CNT_W-1:0] drop_q;
  logic [PKT_W-1:0] cout_q [NUM_CHILD];
  logic [PKT_W-1:0] hold_q [NUM_CHILD];
  logic [PKT_W-1:0] head   [NUM_CHILD];
  logic [NUM_CHILD-1:0] cres_q;
  logic [PKT_W-1:0] dout_q, dout_d, last_q, last_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [31:0]          sel;
  logic                 din_v, legal, arb_found;
  int                   arb_idx, arb_gidx;
  logic [NUM_CHILD-1:0] push, pop, full, empty, rej, grant, hold_v, cd_v;

  assign sel   = sel_field({{(MAX_PKT_W-PKT_W){1'b0}}, din_q}, SEL_LSB, SEL_W);
  assign din_v = din_q[VB];
  assign legal = (sel < 32'(NUM_CHILD));

  for (genvar g = 0; g < NUM_CHILD; g++) begin : g_child
    leaf_sync_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push[g]),
      .din_i   (din_q),
      .pop_i   (pop[g]),
      .dout_o  (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
    assign child_din[g*PKT_W +: PKT_W] = cout_q[g];
    assign hold_v[g] = hold_q[g][VB];
    assign cd_v[g]   = child_dout[g*PKT_W + VB];
  end

  always_comb begin
    push = '0;
    pop  = '0;
    rej  = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      push[i] = din_v && legal && (sel == 32'(i));
      pop[i]  = !empty[i] && (!cout_q[i][VB] || child_ready[i]);
      rej[i]  = push[i] && full[i] && !pop[i];
    end
  end

  // Round-robin: search occupied holds starting at ptr_q; a BFT resend freezes the arbiter.
  always_comb begin
    grant     = '0;
    arb_found = 1'b0;
    arb_idx   = 0;
    arb_gidx  = 0;
    dout_d    = '0;
    last_d    = last_q;
    ptr_d     = ptr_q;
    for (int k = 0; k < NUM_CHILD; k++) begin
      arb_idx = (int'(ptr_q) + k) % NUM_CHILD;
      if (!arb_found && hold_v[arb_idx]) begin
        arb_found = 1'b1;
        arb_gidx  = arb_idx;
      end
    end
    if (resend_in) begin
      dout_d = last_q;
    end else if (arb_found) begin
      grant[arb_gidx] = 1'b1;
      dout_d          = hold_q[arb_gidx];
      last_d          = hold_q[arb_gidx];
      ptr_d           = PW'((arb_gidx + 1) % NUM_CHILD);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q    <= '0;
      resend_q <= 1'b0;
      ap_q     <= 1'b0;
      drop_q   <= '0;
      dout_q   <= '0;
      last_q   <= '0;
      ptr_q    <= '0;
      cres_q   <= '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
        cout_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      din_q    <= din_leaf_bft2interface;
      resend_q <= |rej;
      ap_q     <= ap_start;
      if (din_v && !legal && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
      dout_q <= dout_d;
      last_q <= last_d;
      ptr_q  <= ptr_d;
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (!cout_q[i][VB] || child_ready[i]) cout_q[i] <= empty[i] ? '0 : head[i];
        if (cd_v[i] && (!hold_v[i] || grant[i])) hold_q[i] <= child_dout[i*PKT_W +: PKT_W];
        else if (grant[i])                       hold_q[i] <= '0;
        cres_q[i] <= cd_v[i] && hold_v[i] && !grant[i];
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign resend_out              = resend_q;
  assign child_resend            = cres_q;
  assign child_ap_start          = {NUM_CHILD{ap_q}};
  assign drop_cnt                = drop_q;

endmodule
